// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - line refill/writeback responder over a word-addressed backing store
// Serves one cache-line request at a time: refills after LATENCY idle cycles, writebacks end with a WR_DONE pulse.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  wr_done_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o
);

  localparam int BYTE_OFF = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int BEAT_W   = $clog2(LINE_WORDS);
  localparam int LINE_W   = IDX_W - BEAT_W;
  localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ_BURST,
    ST_WRITE_BURST,
    ST_WRITE_ACK
  } state_t;

  state_t                  state_q;
  logic [LINE_W-1:0]       line_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [BEAT_W-1:0]       beat_d;
  logic [LAT_W-1:0]        lat_q;
  logic                    req_ready_q;
  logic                    wr_ready_q;
  logic                    wr_done_q;
  logic                    rd_valid_q;
  logic                    rd_last_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [IDX_W-1:0]        word_idx;
  logic                    mem_we;
  logic                    unused_addr;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  // Address bits below the line and above the storage size are intentionally dropped (alignment and wrap).
  assign unused_addr = ^req_addr_i;
  assign beat_d      = beat_q + BEAT_W'(1);
  assign word_idx    = {line_q, beat_q};
  assign mem_we      = !reset_i && (state_q == ST_WRITE_BURST) && wr_valid_i;

  // Storage is deliberately outside the reset domain so aborted or reset transactions keep prior contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[word_idx] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            line_q      <= req_addr_i[BYTE_OFF+BEAT_W +: LINE_W];
            beat_q      <= '0;
            lat_q       <= '0;
            req_ready_q <= 1'b0;
            if (req_write_i) begin
              state_q    <= ST_WRITE_BURST;
              wr_ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q    <= ST_READ_BURST;
            rd_valid_q <= 1'b1;
            rd_last_q  <= 1'b0;
            rd_data_q  <= mem_q[word_idx];
            beat_q     <= beat_d;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_READ_BURST: begin
          if (rd_last_q) begin
            state_q     <= ST_IDLE;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            req_ready_q <= 1'b1;
            beat_q      <= '0;
          end else begin
            rd_data_q <= mem_q[word_idx];
            rd_last_q <= (beat_q == BEAT_LAST);
            beat_q    <= beat_d;
          end
        end
        ST_WRITE_BURST: begin
          if (wr_valid_i) begin
            if (beat_q == BEAT_LAST) begin
              state_q    <= ST_WRITE_ACK;
              wr_ready_q <= 1'b0;
              wr_done_q  <= 1'b1;
              beat_q     <= '0;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        ST_WRITE_ACK: begin
          state_q     <= ST_IDLE;
          wr_done_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          beat_q      <= '0;
          lat_q       <= '0;
          req_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
          wr_done_q   <= 1'b0;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign wr_done_o   = wr_done_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_last_o   = rd_last_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: DATA_MEMORY_RESPONDER

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of REQ_ADDR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one beat (one word).
REQ-003 SHALL have parameter LINE_WORDS, default 4, beats per cache line (power of 2, >=2).
REQ-004 SHALL have parameter MEM_DEPTH, default 1024, words of backing storage (power of 2, multiple of LINE_WORDS).
REQ-005 SHALL have parameter LATENCY, default 2, idle cycles before first read beat (>=1).
REQ-006 SHALL have a single clock and a synchronous, active-high reset: CLK input 1, rising-edge clock; RESET input 1, synchronous reset.
REQ-007 SHALL have port REQ_VALID, input, 1, line request from data cache.
REQ-008 SHALL have port REQ_READY, output, 1, responder can accept a request.
REQ-009 SHALL have port REQ_WRITE, input, 1, 1 = line writeback, 0 = line refill.
REQ-010 SHALL have port REQ_ADDR, input, ADDR_WIDTH, byte address of line.
REQ-011 SHALL have port WR_VALID, input, 1, writeback beat valid.
REQ-012 SHALL have port WR_DATA, input, DATA_WIDTH, writeback beat data.
REQ-013 SHALL have port WR_READY, output, 1, responder accepts writeback beats.
REQ-014 SHALL have port WR_DONE, output, 1, one-cycle writeback-complete pulse.
REQ-015 SHALL have port RD_VALID, output, 1, refill beat valid.
REQ-016 SHALL have port RD_DATA, output, DATA_WIDTH, refill beat data.
REQ-017 SHALL have port RD_LAST, output, 1, final refill beat.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, READ_BURST, WRITE_BURST, WRITE_ACK; all outputs registered.
REQ-019 SHALL drive REQ_READY=1 only in IDLE; request accepted on an edge with REQ_VALID=1 and REQ_READY=1 (cycle T).
REQ-020 SHALL compute line base word index = (REQ_ADDR >> log2(DATA_WIDTH/8)) mod MEM_DEPTH with low log2(LINE_WORDS) bits forced to 0; unaligned low address bits ignored, out-of-range addresses wrap.
REQ-021 SHALL, on accepted read, go IDLE->WAIT, hold LATENCY cycles (T+1..T+LATENCY), then READ_BURST.
REQ-022 SHALL in READ_BURST emit beats 0..LINE_WORDS-1 in consecutive cycles from T+LATENCY+1, RD_VALID=1, RD_DATA=mem[base+beat], no backpressure.
REQ-023 SHALL assert RD_LAST together with RD_VALID on beat LINE_WORDS-1 only, then return to IDLE (REQ_READY=1 the following cycle).
REQ-024 SHALL, on accepted write, go IDLE->WRITE_BURST with WR_READY=1 from T+1.
REQ-025 SHALL in WRITE_BURST store WR_DATA to mem[base+count] on each edge with WR_VALID=1, increment beat counter; idle (WR_VALID=0) cycles allowed, stall without penalty.
REQ-026 SHALL after storing beat LINE_WORDS-1 deassert WR_READY, enter WRITE_ACK, pulse WR_DONE=1 for exactly one cycle, then IDLE.
REQ-027 SHALL ignore WR_VALID outside WRITE_BURST and REQ_VALID outside IDLE (no state change, no memory write).
REQ-028 SHALL keep RD_VALID, RD_LAST, WR_DONE at 0 whenever not specified above; RD_DATA value don't-care when RD_VALID=0.
REQ-029 SHALL never assert WR_READY and RD_VALID in the same cycle.
REQ-030 SHALL make data written by a completed writeback visible to any subsequently accepted refill of the same line.

Reset
REQ-031 SHALL on RESET=1 at an edge enter IDLE, clear beat/latency counters, set REQ_READY=1, WR_READY=0, WR_DONE=0, RD_VALID=0, RD_LAST=0, RD_DATA=0.
REQ-032 SHALL on reset mid-burst abort the transaction without further beats or WR_DONE; words already written stay written; storage contents are not cleared by reset.
REQ-033 SHALL give RESET priority over any simultaneous REQ_VALID or WR_VALID.

Verification
REQ-034 Reset then idle -> REQ_READY=1, RD_VALID=0, WR_READY=0, WR_DONE=0.
REQ-035 Write line addr 0x40 beats 0x11,0x22,0x33,0x44 back-to-back, then read 0x40 -> WR_DONE single pulse after 4th beat; refill beats 0x11..0x44 at T+3..T+6, RD_LAST only at T+6, REQ_READY at T+7.
REQ-036 Write with WR_VALID gaps (beat, gap, gap, beat, beat, beat) -> WR_READY stays 1, only 4 words stored, WR_DONE once.
REQ-037 Read addr 0x4C (unaligned) and addr MEM_DEPTH*4+0x40 -> both return line 0x40 data.
REQ-038 RESET asserted after 2nd read beat -> no further RD_VALID, no RD_LAST; REQ_READY=1 next cycle; new request then served normally.
REQ-039 REQ_VALID held high during a burst and WR_VALID during a read -> ignored; memory unchanged, only one transaction served.
